// File: rtl/iterative_multiplier_pkg.sv
// Shared definitions for the iterative signed multiplier.
//   DATA_WIDTH / COUNT_WIDTH : operand width and iteration counter width
//   state_t                  : controller states
//   ALU_OP_MULT              : ALU-op code that decode turns into ctrl_MULT
package iterative_multiplier_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned COUNT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] ALU_OP_MULT = 5'b00110;

endpackage

// File: rtl/mult_iter_step.sv
// One shift-and-add iteration of the unsigned magnitude multiplier.
//   acc         : 64-bit partial product accumulator
//   mplier      : remaining multiplier bits (LSB consumed this step)
//   mcand       : multiplicand magnitude
//   acc_next    : accumulator after conditional add and right shift
//   mplier_next : multiplier shifted right by one
module mult_iter_step
  import iterative_multiplier_pkg::*;
(
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   mplier,
  input  logic [DATA_WIDTH-1:0]   mcand,
  output logic [2*DATA_WIDTH-1:0] acc_next,
  output logic [DATA_WIDTH-1:0]   mplier_next
);

  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH:0]   upper_sum;

  always_comb begin
    addend      = mplier[0] ? mcand : '0;
    // Carry out of the upper half is kept as bit 64 so the shift brings it back in.
    upper_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, addend};
    acc_next    = (2*DATA_WIDTH)'({upper_sum, acc[DATA_WIDTH-1:0]} >> 1);
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle signed 32x32 multiplier (shift-and-add on magnitudes, sign fixed
// up at the end).
//   clock, reset          : rising-edge clock, async active-high reset
//   ctrl_MULT             : start pulse; operands sampled on the same edge
//   data_operandA/B       : two's complement operands
//   data_result           : low 32 bits of the signed product, held until next DONE
//   data_exception        : product does not fit in 32 signed bits
//   data_resultRDY        : one-cycle pulse when data_result is valid
//   busy                  : high while iterating
module iterative_multiplier #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ITERATIONS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_MULT,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  busy
);

  import iterative_multiplier_pkg::*;

  localparam int unsigned ACC_W = 2 * DATA_WIDTH;

  state_t                 state, state_next;
  logic [ACC_W-1:0]       acc, acc_step, prod;
  logic [DATA_WIDTH-1:0]  mcand, mplier, mplier_step;
  logic [DATA_WIDTH-1:0]  abs_a, abs_b;
  logic                   neg;
  logic [COUNT_WIDTH-1:0] count;
  logic                   last_iter;
  logic                   overflow;

  mult_iter_step u_step (
    .acc         (acc),
    .mplier      (mplier),
    .mcand       (mcand),
    .acc_next    (acc_step),
    .mplier_next (mplier_step)
  );

  always_comb begin
    // -(-2^31) wraps back to 0x8000_0000, which is the correct unsigned magnitude.
    abs_a     = data_operandA[DATA_WIDTH-1] ? -data_operandA : data_operandA;
    abs_b     = data_operandB[DATA_WIDTH-1] ? -data_operandB : data_operandB;
    last_iter = (count == COUNT_WIDTH'(ITERATIONS - 1));
    prod      = neg ? -acc : acc;
    // Fits in 32 signed bits only when bits 63..31 are a pure sign extension.
    overflow  = !((&prod[ACC_W-1:DATA_WIDTH-1]) || !(|prod[ACC_W-1:DATA_WIDTH-1]));
    busy      = (state == ST_RUN);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ctrl_MULT) state_next = ST_RUN;
      ST_RUN: begin
        if (ctrl_MULT)      state_next = ST_RUN;
        else if (last_iter) state_next = ST_DONE;
      end
      ST_DONE: state_next = ctrl_MULT ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      neg            <= 1'b0;
      count          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      // A start from any state (including mid-run abort) relatches and restarts.
      if (ctrl_MULT) begin
        mcand  <= abs_a;
        mplier <= abs_b;
        neg    <= data_operandA[DATA_WIDTH-1] ^ data_operandB[DATA_WIDTH-1];
        acc    <= '0;
        count  <= '0;
      end else if (state == ST_RUN) begin
        acc    <= acc_step;
        mplier <= mplier_step;
        count  <= count + 1'b1;
      end

      // DONE results are captured even when a new start lands on the same edge.
      data_resultRDY <= (state == ST_DONE);
      if (state == ST_DONE) begin
        data_result    <= prod[DATA_WIDTH-1:0];
        data_exception <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
module tb_iterative_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;

  iterative_multiplier #(.DATA_WIDTH(32), .ITERATIONS(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference: full-precision signed product, overflow when outside int32 range.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  // Issue one start and observe 37 cycles; k counts cycles after the start edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int rdy_at, output int rdy_cnt, output int busy_cnt,
                       output logic [31:0] res, output logic exc);
    rdy_at = -1; rdy_cnt = 0; busy_cnt = 0; res = '0; exc = 1'b0;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = a; data_operandB = b;
    @(posedge clock);
    for (int k = 0; k <= 36; k++) begin
      @(negedge clock);
      if (k == 0) begin
        ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
      end
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (rdy_at < 0) begin rdy_at = k; res = data_result; exc = data_exception; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", data_exception); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int at, cnt, bc; logic [31:0] r, er; logic e, ee;
    model(32'd3, 32'd7, er, ee);
    do_op(32'd3, 32'd7, at, cnt, bc, r, e);
    checks++; if (at !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", at); end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL basic_rdy_count got %0d want 1", cnt); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d want 32", bc); end
    checks++; if (r !== er) begin errors++; $display("FAIL basic_result got %h want %h", r, er); end
    checks++; if (e !== ee) begin errors++; $display("FAIL basic_exc got %b want %b", e, ee); end
  endtask

  task automatic test_table(input string name, input logic [31:0] ta[], input logic [31:0] tb[]);
    int at, cnt, bc; logic [31:0] r, er; logic e, ee;
    for (int i = 0; i < ta.size(); i++) begin
      model(ta[i], tb[i], er, ee);
      do_op(ta[i], tb[i], at, cnt, bc, r, e);
      checks++;
      if (at !== 33 || cnt !== 1 || r !== er || e !== ee) begin
        errors++;
        $display("FAIL %s[%0d] %h*%h got rdy_at=%0d cnt=%0d res=%h exc=%b want rdy_at=33 cnt=1 res=%h exc=%b",
                 name, i, ta[i], tb[i], at, cnt, r, e, er, ee);
      end
    end
  endtask

  task automatic test_signs();
    logic [31:0] a[] = '{32'hFFFF_FFFB, 32'hFFFF_FFFC};
    logic [31:0] b[] = '{32'd6,         32'hFFFF_FFFC};
    test_table("signs", a, b);
  endtask

  task automatic test_overflow();
    logic [31:0] a[] = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b[] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000, 32'h0000_0001, 32'h8000_0000};
    test_table("overflow", a, b);
  endtask

  task automatic test_random();
    logic [31:0] a[] = new[16];
    logic [31:0] b[] = new[16];
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        a[i] = $urandom; b[i] = $urandom;
      end else begin
        a[i] = 32'($signed(16'($urandom))); b[i] = 32'($signed(15'($urandom)));
      end
    end
    test_table("random", a, b);
  endtask

  task automatic test_restart();
    int cnt = 0, at = -1; logic [31:0] r = '0, er; logic ee;
    model(32'd2, 32'd9, er, ee);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd7;
    @(posedge clock);
    for (int k = 0; k <= 46; k++) begin
      @(negedge clock);
      if (k == 0 || k == 10) begin
        ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
      end
      if (k == 9) begin ctrl_MULT = 1'b1; data_operandA = 32'd2; data_operandB = 32'd9; end
      if (data_resultRDY) begin cnt++; if (at < 0) begin at = k; r = data_result; end end
    end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL restart_rdy_count got %0d want 1", cnt); end
    checks++; if (at !== 43) begin errors++; $display("FAIL restart_latency got %0d want 43", at); end
    checks++; if (r !== er) begin errors++; $display("FAIL restart_result got %h want %h", r, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1 = 32'hFFFF_FFF9, b1 = 32'd123456, a2, b2, er1, er2;
    logic ee1, ee2;
    logic [31:0] r[2]; logic e[2]; int at[2]; int cnt = 0; logic busy_at33 = 1'b0;
    a2 = $urandom; b2 = 32'($signed(12'($urandom)));
    model(a1, b1, er1, ee1);
    model(a2, b2, er2, ee2);
    at[0] = -1; at[1] = -1;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = a1; data_operandB = b1;
    @(posedge clock);
    for (int k = 0; k <= 68; k++) begin
      @(negedge clock);
      if (k == 0 || k == 33) begin
        ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
      end
      if (k == 32) begin ctrl_MULT = 1'b1; data_operandA = a2; data_operandB = b2; end
      if (k == 33) busy_at33 = busy;
      if (data_resultRDY) begin
        if (cnt < 2) begin at[cnt] = k; r[cnt] = data_result; e[cnt] = data_exception; end
        cnt++;
      end
    end
    checks++; if (cnt !== 2) begin errors++; $display("FAIL b2b_rdy_count got %0d want 2", cnt); end
    checks++;
    if (at[0] !== 33 || r[0] !== er1 || e[0] !== ee1) begin
      errors++; $display("FAIL b2b_first got at=%0d res=%h exc=%b want at=33 res=%h exc=%b", at[0], r[0], e[0], er1, ee1);
    end
    checks++;
    if (at[1] !== 66 || r[1] !== er2 || e[1] !== ee2) begin
      errors++; $display("FAIL b2b_second got at=%0d res=%h exc=%b want at=66 res=%h exc=%b", at[1], r[1], e[1], er2, ee2);
    end
    checks++; if (busy_at33 !== 1'b1) begin errors++; $display("FAIL b2b_busy_after_done got %b want 1", busy_at33); end
  endtask

  task automatic test_reset_mid_run();
    int at, cnt, bc, pulses = 0; logic [31:0] r; logic e; logic busy_before = 1'b0;
    // Leave a nonzero result with exception set so the reset clearing is visible.
    do_op(32'h8000_0000, 32'hFFFF_FFFF, at, cnt, bc, r, e);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd1234; data_operandB = 32'd77;
    @(posedge clock);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clock);
      if (k == 0) ctrl_MULT = 1'b0;
      if (data_resultRDY) pulses++;
      if (k == 14) busy_before = busy;
    end
    reset = 1'b1;
    #1;
    checks++; if (busy_before !== 1'b1) begin errors++; $display("FAIL rst_mid_was_busy got %b want 1", busy_before); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (data_resultRDY !== 1'b0 || pulses !== 0) begin errors++; $display("FAIL rst_mid_rdy got %b pulses=%0d want 0", data_resultRDY, pulses); end
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL rst_mid_exc got %b want 0", data_exception); end
    @(negedge clock);
    reset = 1'b0;
    do_op(32'd10, 32'd10, at, cnt, bc, r, e);
    checks++;
    if (at !== 33 || cnt !== 1 || r !== 32'd100 || e !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after got at=%0d cnt=%0d res=%h exc=%b want at=33 cnt=1 res=64 exc=0", at, cnt, r, e);
    end
  endtask

  task automatic test_hold_zero();
    int at, cnt, bc, bad = 0; logic [31:0] r; logic e;
    do_op(32'h0, 32'h1234_5678, at, cnt, bc, r, e);
    checks++;
    if (at !== 33 || cnt !== 1 || bc !== 32 || r !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL zero_op got at=%0d cnt=%0d busy=%0d res=%h exc=%b want at=33 cnt=1 busy=32 res=0 exc=0", at, cnt, bc, r, e);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      data_operandA = $urandom; data_operandB = $urandom;
      if (data_resultRDY !== 1'b0 || data_result !== 32'h0 || data_exception !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_idle got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid_run();
    test_hold_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
